// File: rtl/player_stepper.sv
// Maze-player position controller: paced, bounds-checked moves confirmed by a wall query to the maze store.
// Optional PLAYER_WRAP_EN: moves off an edge wrap to the opposite edge instead of bumping.
module player_stepper #(
   parameter int COORD_W  = 10,
   parameter int GRID_W   = 48,
   parameter int GRID_H   = 48,
   parameter int START_X  = 1,
   parameter int START_Y  = 2,
   parameter int TICK_DIV = 5000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               home,
   input  logic [3:0]         mov,
   output logic               chk_req,
   output logic [COORD_W-1:0] chk_x,
   output logic [COORD_W-1:0] chk_y,
   input  logic               chk_ack,
   input  logic               chk_wall,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic [COORD_W-1:0] prev_x,
   output logic [COORD_W-1:0] prev_y,
   output logic               moved,
   output logic               bump
);

   localparam int CW1   = COORD_W + 1;
   localparam int CNT_W = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [COORD_W:0]   ONE_C    = CW1'(1);
   localparam logic [COORD_W:0]   GRID_W_C = CW1'(GRID_W);
   localparam logic [COORD_W:0]   GRID_H_C = CW1'(GRID_H);
   localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
   localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CHECK = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tick_s;
   logic               chk_req_q, chk_req_d;
   logic [COORD_W-1:0] chk_x_q, chk_x_d;
   logic [COORD_W-1:0] chk_y_q, chk_y_d;
   logic [COORD_W-1:0] pos_x_q, pos_x_d;
   logic [COORD_W-1:0] pos_y_q, pos_y_d;
   logic [COORD_W-1:0] prev_x_q, prev_x_d;
   logic [COORD_W-1:0] prev_y_q, prev_y_d;
   logic               moved_q, moved_d;
   logic               bump_q, bump_d;
   logic               mov_onehot_s;
   logic               in_range_s;
   logic [COORD_W:0]   raw_x_s, raw_y_s;
   logic [COORD_W:0]   cand_x_s, cand_y_s;

   // Widened by one bit so that stepping below zero lands far outside the grid.
   function automatic logic [COORD_W:0] step_axis(
      input logic [COORD_W-1:0] c,
      input logic               inc,
      input logic               dec
   );
      logic [COORD_W:0] r;
      r = {1'b0, c};
      if (inc) begin
         r = r + ONE_C;
      end else if (dec) begin
         r = r - ONE_C;
      end else begin
         r = {1'b0, c};
      end
      return r;
   endfunction

   // Free-running move-tick divider.
   always_comb begin
      tick_s = (cnt_q == CNT_MAX);
      if (tick_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Candidate target cell for the requested direction.
   always_comb begin
      case (mov)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: mov_onehot_s = 1'b1;
         default:                            mov_onehot_s = 1'b0;
      endcase
      raw_x_s = step_axis(pos_x_q, mov[0], mov[3]);
      raw_y_s = step_axis(pos_y_q, mov[1], mov[2]);
`ifdef PLAYER_WRAP_EN
      if (raw_x_s == GRID_W_C) begin
         cand_x_s = '0;
      end else if (raw_x_s == {CW1{1'b1}}) begin
         cand_x_s = GRID_W_C - ONE_C;
      end else begin
         cand_x_s = raw_x_s;
      end
      if (raw_y_s == GRID_H_C) begin
         cand_y_s = '0;
      end else if (raw_y_s == {CW1{1'b1}}) begin
         cand_y_s = GRID_H_C - ONE_C;
      end else begin
         cand_y_s = raw_y_s;
      end
`else
      cand_x_s = raw_x_s;
      cand_y_s = raw_y_s;
`endif
      in_range_s = (cand_x_s < GRID_W_C) && (cand_y_s < GRID_H_C);
   end

   // Next-state and output logic; home overrides everything except reset.
   always_comb begin
      state_d   = state_q;
      chk_req_d = chk_req_q;
      chk_x_d   = chk_x_q;
      chk_y_d   = chk_y_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      prev_x_d  = prev_x_q;
      prev_y_d  = prev_y_q;
      moved_d   = 1'b0;
      bump_d    = 1'b0;
      if (home) begin
         state_d   = ST_IDLE;
         chk_req_d = 1'b0;
         pos_x_d   = START_XC;
         pos_y_d   = START_YC;
         prev_x_d  = START_XC;
         prev_y_d  = START_YC;
      end else begin
         case (state_q)
            ST_IDLE: begin
               chk_req_d = 1'b0;
               if (tick_s && en && mov_onehot_s) begin
                  if (in_range_s) begin
                     chk_x_d   = cand_x_s[COORD_W-1:0];
                     chk_y_d   = cand_y_s[COORD_W-1:0];
                     chk_req_d = 1'b1;
                     state_d   = ST_CHECK;
                  end else begin
                     bump_d = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CHECK: begin
               // Ticks are deliberately ignored here: one outstanding query at a time.
               if (chk_ack) begin
                  chk_req_d = 1'b0;
                  state_d   = ST_IDLE;
                  if (chk_wall) begin
                     bump_d = 1'b1;
                  end else begin
                     prev_x_d = pos_x_q;
                     prev_y_d = pos_y_q;
                     pos_x_d  = chk_x_q;
                     pos_y_d  = chk_y_q;
                     moved_d  = 1'b1;
                  end
               end else begin
                  chk_req_d = 1'b1;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               chk_req_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         chk_req_q <= 1'b0;
         chk_x_q   <= '0;
         chk_y_q   <= '0;
         pos_x_q   <= START_XC;
         pos_y_q   <= START_YC;
         prev_x_q  <= START_XC;
         prev_y_q  <= START_YC;
         moved_q   <= 1'b0;
         bump_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         chk_req_q <= chk_req_d;
         chk_x_q   <= chk_x_d;
         chk_y_q   <= chk_y_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         prev_x_q  <= prev_x_d;
         prev_y_q  <= prev_y_d;
         moved_q   <= moved_d;
         bump_q    <= bump_d;
      end
   end

   assign chk_req = chk_req_q;
   assign chk_x   = chk_x_q;
   assign chk_y   = chk_y_q;
   assign pos_x   = pos_x_q;
   assign pos_y   = pos_y_q;
   assign prev_x  = prev_x_q;
   assign prev_y  = prev_y_q;
   assign moved   = moved_q;
   assign bump    = bump_q;

endmodule

// File: tb/tb_player_stepper.sv
// Scoreboard bench for player_stepper on a 48x48 grid, start (1,2), TICK_DIV=4.
module tb_player_stepper;

   localparam int CW = 10;
   localparam int GW = 48;
   localparam int GH = 48;
   localparam int SX = 1;
   localparam int SY = 2;

   localparam int EV_CHK   = 0;
   localparam int EV_MOVED = 1;
   localparam int EV_BUMP  = 2;

   typedef struct {
      int kind;
      int x;
      int y;
      int px;
      int py;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          home;
   logic [3:0]    mov;
   logic          chk_req;
   logic [CW-1:0] chk_x, chk_y;
   logic          chk_ack;
   logic          chk_wall;
   logic [CW-1:0] pos_x, pos_y, prev_x, prev_y;
   logic          moved, bump;

   int  n_cmp = 0;
   int  n_err = 0;
   ev_t exp_q[$];
   int  ex, ey, tx, ty;
   bit  at_edge;
   bit  chk_prev;
   ev_t mon_e;
   bit  mon_ok;

   player_stepper #(
      .COORD_W(CW), .GRID_W(GW), .GRID_H(GH),
      .START_X(SX), .START_Y(SY), .TICK_DIV(4)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .home(home), .mov(mov),
      .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
      .chk_ack(chk_ack), .chk_wall(chk_wall),
      .pos_x(pos_x), .pos_y(pos_y), .prev_x(prev_x), .prev_y(prev_y),
      .moved(moved), .bump(bump)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
      end
   endtask

   task automatic push_ev(input int kind, input int x, input int y, input int px, input int py);
      ev_t e;
      e.kind = kind; e.x = x; e.y = y; e.px = px; e.py = py;
      exp_q.push_back(e);
   endtask

   task automatic pop_ev(input int kind, output ev_t e, output bit ok);
      if (exp_q.size() == 0) begin
         check_val("unexpected_event", kind, -1);
         ok = 1'b0;
      end else begin
         e  = exp_q.pop_front();
         ok = 1'b1;
         check_val("event_kind", kind, e.kind);
      end
   endtask

   // Output monitor: every query, commit and bump must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst) begin
         chk_prev = 1'b0;
      end else begin
         if (chk_req && !chk_prev) begin
            pop_ev(EV_CHK, mon_e, mon_ok);
            if (mon_ok) begin
               check_val("chk_x", int'(chk_x), mon_e.x);
               check_val("chk_y", int'(chk_y), mon_e.y);
            end
         end
         if (moved) begin
            pop_ev(EV_MOVED, mon_e, mon_ok);
            if (mon_ok) begin
               check_val("moved_pos_x", int'(pos_x), mon_e.x);
               check_val("moved_pos_y", int'(pos_y), mon_e.y);
               check_val("moved_prev_x", int'(prev_x), mon_e.px);
               check_val("moved_prev_y", int'(prev_y), mon_e.py);
            end
         end
         if (bump) begin
            pop_ev(EV_BUMP, mon_e, mon_ok);
            if (mon_ok) begin
               check_val("bump_pos_x", int'(pos_x), mon_e.x);
               check_val("bump_pos_y", int'(pos_y), mon_e.y);
            end
         end
         if (moved && bump) check_val("moved_and_bump", 1, 0);
         chk_prev = chk_req;
      end
   end

   // Drive a move until the DUT reacts; predicts the query or the edge bump.
   task automatic start_move(input logic [3:0] m, output bit got_chk);
      bit seen;
      tx = ex; ty = ey;
      case (m)
         4'b0001: tx = ex + 1;
         4'b0010: ty = ey + 1;
         4'b0100: ty = ey - 1;
         default: tx = ex - 1;
      endcase
      at_edge = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
`ifdef PLAYER_WRAP_EN
      if (tx < 0)   tx = GW - 1;
      if (tx >= GW) tx = 0;
      if (ty < 0)   ty = GH - 1;
      if (ty >= GH) ty = 0;
      at_edge = 1'b0;
`endif
      if (at_edge) push_ev(EV_BUMP, ex, ey, 0, 0);
      else         push_ev(EV_CHK, tx, ty, 0, 0);
      en = 1'b1; mov = m;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (chk_req || bump) seen = 1'b1;
      end
      en = 1'b0; mov = 4'b0000;
      if (!seen) check_val("move_timeout", 0, 1);
      got_chk = seen && chk_req;
      if (seen) check_val("edge_no_query", int'(chk_req), at_edge ? 0 : 1);
   endtask

   task automatic do_move(input logic [3:0] m, input int ack_dly, input logic wall);
      bit got;
      int cx, cy, n_high;
      start_move(m, got);
      if (got) begin
         cx = int'(chk_x); cy = int'(chk_y); n_high = 1;
         if (wall) push_ev(EV_BUMP, ex, ey, 0, 0);
         else      push_ev(EV_MOVED, tx, ty, ex, ey);
         for (int k = 0; k < ack_dly; k++) begin
            @(negedge clk);
            if (chk_req) n_high++;
            check_val("chk_hold_x", int'(chk_x), cx);
            check_val("chk_hold_y", int'(chk_y), cy);
         end
         check_val("chk_req_cycles", n_high, ack_dly + 1);
         chk_ack = 1'b1; chk_wall = wall;
         @(negedge clk);
         chk_ack = 1'b0; chk_wall = 1'b0;
         check_val("chk_req_drop", int'(chk_req), 0);
         if (!wall) begin ex = tx; ey = ty; end
         @(negedge clk);
         check_val("pulse_len", int'(moved | bump), 0);
      end else begin
         @(negedge clk);
         check_val("bump_len", int'(bump), 0);
      end
   endtask

   logic [4:0] idle_tab [4];
   initial begin
      bit got;
      int seen;
      idle_tab[0] = 5'b1_1001; idle_tab[1] = 5'b1_0000;
      idle_tab[2] = 5'b0_0001; idle_tab[3] = 5'b1_0110;
      rst = 1'b1; en = 1'b0; home = 1'b0; mov = 4'b0000;
      chk_ack = 1'b0; chk_wall = 1'b0;
      ex = SX; ey = SY;
      repeat (2) @(negedge clk);
      check_val("rst_pos_x", int'(pos_x), SX);
      check_val("rst_pos_y", int'(pos_y), SY);
      check_val("rst_prev_x", int'(prev_x), SX);
      check_val("rst_prev_y", int'(prev_y), SY);
      check_val("rst_chk", int'({chk_req, chk_x, chk_y, moved, bump}), 0);
      rst = 1'b0;

      // Idle with a stray ack: nothing may happen.
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         chk_ack = (i >= 5 && i < 9);
         @(negedge clk);
         if (chk_req || moved || bump) seen++;
      end
      chk_ack = 1'b0;
      check_val("idle_quiet", seen, 0);
      check_val("idle_pos_x", int'(pos_x), SX);
      check_val("idle_prev_y", int'(prev_y), SY);

      do_move(4'b0001, 0, 1'b0);
      do_move(4'b0001, 3, 1'b1);
      do_move(4'b1000, 1, 1'b0);
      do_move(4'b1000, 0, 1'b0);
      do_move(4'b1000, 0, 1'b0);
      do_move(4'b0100, 0, 1'b0);
      do_move(4'b0100, 2, 1'b0);
      do_move(4'b0100, 1, 1'b0);
      do_move(4'b0010, 0, 1'b1);

      // Invalid direction codes, or en low, across several ticks.
      foreach (idle_tab[i]) begin
         en = idle_tab[i][4]; mov = idle_tab[i][3:0];
         seen = 0;
         repeat (12) begin
            @(negedge clk);
            if (chk_req || moved || bump) seen++;
         end
         check_val("no_action", seen, 0);
      end
      en = 1'b0; mov = 4'b0000;

      // home mid-check with a same-cycle ack.
      start_move(4'b0001, got);
      check_val("home_got_chk", int'(got), 1);
      home = 1'b1; chk_ack = 1'b1; chk_wall = 1'b0;
      @(negedge clk);
      home = 1'b0; chk_ack = 1'b0;
      check_val("home_chk_req", int'(chk_req), 0);
      check_val("home_pos", int'({pos_x, pos_y}), (SX << CW) | SY);
      check_val("home_prev", int'({prev_x, prev_y}), (SX << CW) | SY);
      check_val("home_pulses", int'(moved | bump), 0);
      @(negedge clk);
      check_val("home_pulses2", int'(moved | bump), 0);
      ex = SX; ey = SY;

      // Async reset mid-check.
      start_move(4'b0010, got);
      check_val("rst_got_chk", int'(got), 1);
      #2 rst = 1'b1;
      #1;
      check_val("arst_chk", int'({chk_req, chk_x, chk_y, moved, bump}), 0);
      check_val("arst_pos", int'({pos_x, pos_y}), (SX << CW) | SY);
      check_val("arst_prev", int'({prev_x, prev_y}), (SX << CW) | SY);
      @(negedge clk);
      rst = 1'b0;
      ex = SX; ey = SY;

      do_move(4'b0001, 1, 1'b0);
      repeat (4) @(negedge clk);
      check_val("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
